bcd_display_scanner: RTL and testbench
======================================

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter DIV, default 1000, clock cycles each digit is driven per slot (DIV >= 1).
REQ-002 SHALL have parameter GUARD, default 8, all-off cycles between digit slots (GUARD >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ones  input  4  BCD units digit from the decade counter chain.
REQ-006 SHALL have port tens  input  4  BCD tens digit.
REQ-007 SHALL have port hundreds  input  4  BCD hundreds digit.
REQ-008 SHALL have port ovf_in  input  1  counter-chain carry-out pulse (hundreds roll-over).
REQ-009 SHALL have port clear_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-010 SHALL have port lzb  input  1  leading-zero blanking enable.
REQ-011 SHALL have port an  output  3  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds.
REQ-012 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 SHALL have port dp  output  1  decimal point, active-low.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag, active-high.

Function
REQ-015 Scan order SHALL be: ones slot, guard, tens slot, guard, hundreds slot, guard, repeat; frame = 3*(DIV+GUARD) cycles.
REQ-016 FSM SHALL have two states, SLOT (DIV cycles) and GUARD (GUARD cycles), plus a 2-bit digit index 0->1->2->0, advanced on each GUARD->SLOT transition.
REQ-017 On the edge entering SLOT, a single cycle-counter SHALL reload to 0; SLOT->GUARD when counter = DIV-1; GUARD->SLOT when counter = GUARD-1.
REQ-018 On the edge entering the ones slot, ones/tens/hundreds and ovf SHALL be captured into snapshot registers; all three slots of that frame display the snapshot (no tearing).
REQ-019 an/seg/dp SHALL be registered and change on the same edge as the state transition that selects them.
REQ-020 During GUARD: an=3'b111, seg=7'h7F, dp=1.
REQ-021 During SLOT: the selected an bit SHALL be 0 and the other two 1, except when blanked (REQ-023), when an=3'b111 and seg=7'h7F.
REQ-022 Decode SHALL be 0:40h 1:79h 2:24h 3:30h 4:19h 5:12h 6:02h 7:78h 8:00h 9:10h; codes 10-15 SHALL show dash 3Fh.
REQ-023 With lzb=1 (sampled at snapshot), hundreds SHALL be blanked when snapshot hundreds=0, and tens when hundreds=0 and tens=0; ones is never blanked; lzb=0 disables blanking.
REQ-024 dp SHALL be 0 only during the hundreds slot when snapshot ovf=1 and hundreds is not blanked; otherwise 1.
REQ-025 ovf SHALL set on a cycle with ovf_in=1 and clear on a cycle with clear_ovf=1 and ovf_in=0; simultaneous ovf_in and clear_ovf SHALL leave ovf=1.
REQ-026 Invalid BCD input SHALL not disturb scan timing; only the displayed glyph changes.

Reset
REQ-027 reset=1 SHALL immediately force an=3'b111, seg=7'h7F, dp=1, ovf=0, snapshots=0, state=GUARD, digit index=2, counter=0.
REQ-028 After reset release, the first ones slot SHALL begin GUARD cycles later, taking a fresh snapshot.
REQ-029 Reset asserted mid-slot or mid-guard SHALL abort the frame with no partial glyph after deassertion.

Verification (DIV=4, GUARD=2)
REQ-030 Digits 3/2/1, lzb=0, release reset -> an=111 for 2 cycles, then an=110 seg=30h for 4, 111 for 2, 101 seg=24h for 4, 111 for 2, 011 seg=79h for 4; period 18.
REQ-031 Digits 0/5/0, lzb=1 -> ones slot seg=40h, tens slot seg=12h, hundreds slot an=111; digits 0/0/0 -> only ones slot lit with 40h.
REQ-032 Change ones 3->7 mid-tens-slot -> current frame keeps 30h; next ones slot shows 78h.
REQ-033 Pulse ovf_in one cycle -> ovf=1 next cycle; next frame hundreds slot dp=0; clear_ovf with ovf_in=0 -> ovf=0; both same cycle -> ovf stays 1.
REQ-034 ones=4'hC -> ones slot seg=3Fh, slot timing unchanged.
REQ-035 Assert reset during tens slot -> outputs all-off immediately; after release, frame restarts per REQ-028.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Time-multiplexes a three-digit BCD value onto a common-anode 7-segment
//   display. The scan order is ones, tens, hundreds. An all-off guard gap
//   separates the digit slots to prevent ghosting.
//   A snapshot of the digits, the overflow flag and lzb is taken as each frame
//   begins. All three slots of a frame therefore show one consistent value.
//
// Parameters
//   DIV   : cycles each digit is driven per slot (>= 1)
//   GUARD : all-off cycles between slots (>= 1)
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   ones      : BCD units digit
//   tens      : BCD tens digit
//   hundreds  : BCD hundreds digit
//   ovf_in    : counter-chain carry-out pulse
//   clear_ovf : synchronous clear of the sticky overflow flag
//   lzb       : leading-zero blanking enable
//   an        : digit enables, active-low (an[0]=ones, an[1]=tens, an[2]=hundreds)
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point, active-low (lit on hundreds when overflowed)
//   ovf       : sticky overflow flag
module bcd_display_scanner #(
  parameter int DIV   = 1000,
  parameter int GUARD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       ovf_in,
  input  logic       clear_ovf,
  input  logic       lzb,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       ovf
);

  localparam int CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {ST_SLOT, ST_GUARD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
  logic        sovf_q, sovf_d, lzb_q, lzb_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        load_snap, blank_h, blank_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F; // non-BCD shows a dash
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    if (state_q == ST_SLOT) begin
      if (cnt_q == DIV_LAST) begin
        state_d = ST_GUARD;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == GUARD_LAST) begin
        state_d = ST_SLOT;
        cnt_d   = '0;
        idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
    end

    // Snapshot on the edge that enters the ones slot.
    // The outputs use the
    // _d copies so that the first slot already shows the fresh value.
    load_snap = (state_q == ST_GUARD) && (cnt_q == GUARD_LAST) && (idx_d == 2'd0);
    ones_d = load_snap ? ones     : ones_q;
    tens_d = load_snap ? tens     : tens_q;
    hund_d = load_snap ? hundreds : hund_q;
    sovf_d = load_snap ? ovf_q    : sovf_q;
    lzb_d  = load_snap ? lzb      : lzb_q;

    // Setting the flag takes priority over clearing it.
    ovf_d = ovf_in | (ovf_q & ~clear_ovf);

    blank_h = lzb_d && (hund_d == 4'd0);
    blank_t = blank_h && (tens_d == 4'd0);

    an_d  = 3'b111;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == ST_SLOT) begin
      case (idx_d)
        2'd0: begin
          an_d  = 3'b110;
          seg_d = seg_decode(ones_d);
        end
        2'd1: begin
          if (!blank_t) begin
            an_d  = 3'b101;
            seg_d = seg_decode(tens_d);
          end
        end
        2'd2: begin
          if (!blank_h) begin
            an_d  = 3'b011;
            seg_d = seg_decode(hund_d);
            dp_d  = ~sovf_d;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_GUARD;
      idx_q   <= 2'd2;  // first GUARD->SLOT advance lands on the ones slot
      cnt_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
      sovf_q  <= 1'b0;
      lzb_q   <= 1'b0;
      ovf_q   <= 1'b0;
      an_q    <= 3'b111;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      sovf_q  <= sovf_d;
      lzb_q   <= lzb_d;
      ovf_q   <= ovf_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner
//   Directed bench for bcd_display_scanner with DIV=4, GUARD=2 (18-cycle frame).
//   Outputs are sampled on the falling clock edge.
module tb_bcd_display_scanner;

  localparam int DIV   = 4;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ones, tens, hundreds;
  logic       ovf_in, clear_ovf, lzb;
  logic [2:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  bcd_display_scanner #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk      (clk),
    .reset    (reset),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds),
    .ovf_in   (ovf_in),
    .clear_ovf(clear_ovf),
    .lzb      (lzb),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Checks one whole frame.
  // The call must start in the first guard cycle before a ones slot.
  // lit[k] : slot k is lit.
  // s0..s2 : expected glyphs.
  // dp2    : expect dp lit in the hundreds slot.
  // At cycle chg_c, ones is changed to chg_v (-1 disables the change).
  task automatic frame(input string tag, input logic [2:0] lit,
                       input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic dp2, input int chg_c, input logic [3:0] chg_v);
    logic [6:0]  sk;
    logic [10:0] exp;
    int c;
    c = 0;
    for (int k = 0; k < 3; k++) begin
      sk = (k == 0) ? s0 : (k == 1) ? s1 : s2;
      for (int i = 0; i < GUARD + DIV; i++) begin
        if (i < GUARD || !lit[k]) exp = {3'b111, 7'h7F, 1'b1};
        else exp = {~(3'b001 << k), sk, ~((k == 2) && dp2)};
        chk($sformatf("%s c%0d", tag, c), {21'd0, an, seg, dp}, {21'd0, exp});
        if (c == chg_c) ones = chg_v;
        c++;
        step(1);
      end
    end
  endtask

  initial begin
    reset = 1'b1; ones = 4'd3; tens = 4'd2; hundreds = 4'd1;
    ovf_in = 1'b0; clear_ovf = 1'b0; lzb = 1'b0;
    step(3);
    chk("reset_out", {21'd0, an, seg, dp}, {21'd0, 3'b111, 7'h7F, 1'b1});
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    reset = 1'b0;

    // Digits 3/2/1, no blanking
    frame("f321", 3'b111, 7'h30, 7'h24, 7'h79, 1'b0, -1, 4'd0);

    // Leading-zero blanking
    ones = 4'd0; tens = 4'd5; hundreds = 4'd0; lzb = 1'b1;
    frame("f050", 3'b011, 7'h40, 7'h12, 7'h7F, 1'b0, -1, 4'd0);
    tens = 4'd0;
    frame("f000", 3'b001, 7'h40, 7'h7F, 7'h7F, 1'b0, -1, 4'd0);
    lzb = 1'b0;
    frame("f000nb", 3'b111, 7'h40, 7'h40, 7'h40, 1'b0, -1, 4'd0);

    // Change ones mid-tens-slot: the frame keeps its snapshot
    ones = 4'd3; tens = 4'd2; hundreds = 4'd1;
    frame("tear_a", 3'b111, 7'h30, 7'h24, 7'h79, 1'b0, 9, 4'd7);
    frame("tear_b", 3'b111, 7'h78, 7'h24, 7'h79, 1'b0, -1, 4'd0);

    // Invalid BCD shows a dash with unchanged timing
    ones = 4'hC;
    frame("dash", 3'b111, 7'h3F, 7'h24, 7'h79, 1'b0, -1, 4'd0);
    ones = 4'd3;

    // Overflow set, then displayed on the hundreds dp
    ovf_in = 1'b1;
    step(1);
    ovf_in = 1'b0;
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    step(17);
    frame("ovf_dp", 3'b111, 7'h30, 7'h24, 7'h79, 1'b1, -1, 4'd0);
    // dp is suppressed when the hundreds digit is blanked
    hundreds = 4'd0; tens = 4'd5; ones = 4'd0; lzb = 1'b1;
    frame("ovf_blank", 3'b011, 7'h40, 7'h12, 7'h7F, 1'b0, -1, 4'd0);
    ones = 4'd3; tens = 4'd2; hundreds = 4'd1; lzb = 1'b0;
    // Simultaneous set and clear keeps the flag
    ovf_in = 1'b1; clear_ovf = 1'b1;
    step(1);
    ovf_in = 1'b0; clear_ovf = 1'b0;
    chk("ovf_both", {31'd0, ovf}, 32'd1);
    step(1);
    chk("ovf_hold", {31'd0, ovf}, 32'd1);
    step(16);
    // Clear
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    chk("ovf_clr", {31'd0, ovf}, 32'd0);
    step(17);
    frame("ovf_gone", 3'b111, 7'h30, 7'h24, 7'h79, 1'b0, -1, 4'd0);

    // Reset in the middle of the tens slot
    ovf_in = 1'b1;
    step(1);
    ovf_in = 1'b0;
    step(8);
    chk("pre_rst_an", {29'd0, an}, {29'd0, 3'b101});
    #2 reset = 1'b1;
    #1;
    chk("rst_async", {21'd0, an, seg, dp}, {21'd0, 3'b111, 7'h7F, 1'b1});
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    step(1);
    reset = 1'b0;
    frame("post_rst", 3'b111, 7'h30, 7'h24, 7'h79, 1'b0, -1, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
